race_edge_decoder: RTL
======================

// Module: race_edge_decoder
// PURPOSE
//  Receiving end of the temporal (race-logic) interface: converts 1->0 transitions on N lines
//  (e.g. bitonic sorter sorted_out) into binary arrival times counted in clk cycles from start.
//  Streams one {index, time, missing} record per line over valid/ready and flags ordering
//  violations, so sorter outputs are checked in hardware instead of by waveform inspection.
// PARAMETERS
//  N            32  number of temporal lines (power of two, >=2)
//  TW           8   time-stamp width; window timeout = 2**TW-1 cycles
//  SYNC_STAGES  2   synchroniser flops per line (>=2); adds fixed, uncompensated latency
// PORTS
//  clk          in   1          clock
//  rst          in   1          asynchronous active-high reset
//  start        in   1          1-cycle pulse: open capture window (honoured only in IDLE)
//  edge_in      in   [0:N-1]    temporal lines, idle high, event = 1->0 transition
//  busy         out  1          high in CAPTURE or DRAIN
//  out_valid    out  1          record valid
//  out_ready    in   1          consumer accepts record
//  out_idx      out  $clog2(N)  line index of record
//  out_time     out  TW         cycles from start to detected edge
//  out_missing  out  1          line saw no edge before timeout (out_time = all-ones)
//  done         out  1          1-cycle pulse after final record handshake
//  order_err    out  1          sticky: some time[i] < time[i-1]; cleared by next accepted start
// BEHAVIOUR
//  Reset: state IDLE; busy, out_valid, done, order_err, out_missing = 0; out_idx, out_time = 0;
//   counter, capture flags, time table cleared; sync flops preset to 1 (no false edge).
//  IDLE: start -> counter <= 0, all capt[i] <= 0, order_err <= 0, go CAPTURE next cycle.
//  CAPTURE: counter +1 per cycle, saturates at 2**TW-1. Synced line i with prev=1, cur=0 and
//   capt[i]=0 -> time[i] <= counter, capt[i] <= 1. Line already low on first CAPTURE cycle ->
//   time 0. Only first edge per line counts; later 0->1->0 ignored. Simultaneous edges on any
//   subset all captured same cycle with equal times.
//  CAPTURE exit: all capt set, or counter == 2**TW-1 (uncaptured lines marked missing,
//   time = all-ones) -> DRAIN. Edge on timeout cycle still captured with time 2**TW-1, not missing.
//  Recorded time = true arrival + SYNC_STAGES (+0/1 sampling jitter); not compensated.
//  DRAIN: records in index order 0..N-1; out_valid held, payload stable until out_ready.
//   Handshake when out_valid & out_ready; next record presented the following cycle
//   (back-to-back allowed, 1 record/cycle max). On accept of idx i>0, compare with previous
//   accepted time: time[i] < time[i-1] sets order_err (missing = all-ones, so missing then
//   captured is an error). After idx N-1 handshake: out_valid=0, done=1 one cycle, IDLE.
//  start during CAPTURE/DRAIN ignored. start same cycle as reset deassert edge: ignored.
//  rst mid-operation: immediate abort to reset state; partial results discarded, no done.
//  Counter and time table never wrap; TW-bit unsigned compare only.
// STRUCTURE
//  Package race_pkg: state enum {IDLE, CAPTURE, DRAIN}; record struct {idx, time, missing};
//   shared defaults RACE_N=32, RACE_TW=8 (also used by sorter benches).
//  Sub-module edge_sync_detect (one per line, generate loop): SYNC_STAGES sync chain plus
//   falling-edge detect, outputs fall pulse and current level. Top holds FSM, counter,
//   time table (N x TW regs), drain index, order checker.
// TESTING
//  1 Reset mid-CAPTURE (cycle 10) -> busy=0, out_valid=0, no done, order_err=0, restart clean.
//  2 N=32 lines, line i falls at cycle 3+2i after start, out_ready=1 -> 32 records,
//    idx 0..31, out_time = 3+2i+SYNC_STAGES (+-1), order_err=0, done 1 cycle after idx 31.
//  3 Feed bench's unsorted drop order (line 12 first ... line 8 last) directly -> order_err=1;
//    through bitonic_sort_32 -> order_err=0, times non-decreasing.
//  4 Lines 5,6,7 fall same cycle -> equal out_time; lines 30,31 never fall ->
//    out_missing=1, out_time=255, decoder leaves CAPTURE at counter 255.
//  5 out_ready random 30% duty -> payload stable while stalled, no record lost/duplicated.
//  6 start pulsed during DRAIN -> ignored; line low before start -> time 0 (+sync);
//    glitch 1->0->1->0 -> only first edge recorded.

Source files
------------

// File: rtl/race_pkg.sv
// Shared definitions for the race-logic edge decoder and the sorter benches
// that feed it: FSM states, the streamed record layout and default sizes.
package race_pkg;

    // Default geometry shared with the sorter benches.
    localparam int RACE_N  = 32;
    localparam int RACE_TW = 8;
    localparam int RACE_IW = $clog2(RACE_N);

    // Decoder FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } race_state_e;

    // One streamed record at the default geometry.
    // "time" is a keyword, so the stamp field is called tstamp.
    typedef struct packed {
        logic [RACE_IW-1:0] idx;
        logic [RACE_TW-1:0] tstamp;
        logic               missing;
    } race_rec_t;

endpackage

// File: rtl/edge_sync_detect.sv
// Per-line synchroniser and falling-edge detector. The chain and the
// previous-level flop come out of reset high, so an idle-high line never
// produces a spurious fall.
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the synchroniser and remember the last
    // synchronised level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign fall  = prev_q & ~level;

endmodule

// File: rtl/race_edge_decoder.sv
// Race-logic receiver: time-stamps the first 1->0 transition on each of N
// lines relative to start, then streams {idx, time, missing} records in
// index order and flags any record whose time is below its predecessor's.
//
// Output handshake: a record transfers on a rising clk edge where
// out_valid & out_ready. While out_valid is high and out_ready is low,
// out_idx/out_time/out_missing hold steady. out_valid never drops without
// a transfer; the next record (if any) appears on the cycle after a transfer.
module race_edge_decoder
    import race_pkg::*;
#(
    parameter int N           = RACE_N,
    parameter int TW          = RACE_TW,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [0:N-1]         edge_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [TW-1:0]        out_time,
    output logic                 out_missing,
    output logic                 done,
    output logic                 order_err
);

    localparam int            IW    = $clog2(N);
    localparam logic [TW-1:0] T_MAX = '1;
    localparam logic [IW-1:0] LAST  = IW'(N - 1);

    // FSM state is kept as a named signal so checkers can bind to it.
    race_state_e   state;
    logic [TW-1:0] counter;
    logic [N-1:0]  capt;
    logic [TW-1:0] time_tab [N];
    logic [TW-1:0] prev_time;
    logic          armed;

    logic [N-1:0]  level;
    logic [N-1:0]  fall;
    logic [N-1:0]  hit;
    logic          all_capt;
    logic          timeout;
    logic [IW-1:0] nxt_idx;

    // One synchroniser + edge detector per temporal line.
    for (genvar g = 0; g < N; g++) begin : g_line
        edge_sync_detect #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .din   (edge_in[g]),
            .level (level[g]),
            .fall  (fall[g])
        );
    end

    // Lines captured this cycle: first fall only; a line already low on the
    // first capture cycle (counter still 0) counts as arriving at time 0.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = (state == CAPTURE) && !capt[i] &&
                     (fall[i] || ((counter == '0) && !level[i]));
        end
    end

    assign all_capt = &(capt | hit);
    assign timeout  = (counter == T_MAX);
    assign nxt_idx  = out_idx + 1'b1;

    // Time table: stamp captured lines with the current count; on the
    // timeout cycle any still-uncaptured line is stamped all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) time_tab[i] <= '0;
        end else if (state == CAPTURE) begin
            for (int i = 0; i < N; i++) begin
                if (hit[i])
                    time_tab[i] <= counter;
                else if (!capt[i] && timeout)
                    time_tab[i] <= T_MAX;
            end
        end
    end

    // Control FSM: capture window, record drain and ordering check.
    // armed blocks a start that coincides with the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            capt        <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_time    <= '0;
            out_missing <= 1'b0;
            done        <= 1'b0;
            order_err   <= 1'b0;
            prev_time   <= '0;
            armed       <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && armed) begin
                        counter   <= '0;
                        capt      <= '0;
                        order_err <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    capt <= capt | hit;
                    if (!timeout)
                        counter <= counter + 1'b1;
                    if (all_capt || timeout)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!out_valid) begin
                        out_valid   <= 1'b1;
                        out_idx     <= '0;
                        out_time    <= time_tab[0];
                        out_missing <= ~capt[0];
                    end else if (out_ready) begin
                        if ((out_idx != '0) && (out_time < prev_time))
                            order_err <= 1'b1;
                        prev_time <= out_time;
                        if (out_idx == LAST) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_idx     <= nxt_idx;
                            out_time    <= time_tab[nxt_idx];
                            out_missing <= ~capt[nxt_idx];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
